// File: rtl/ctrl_pkg.sv
// ctrl_pkg: opcode and state encodings plus IR field positions shared by ctrl_fsm.
// Latency: none (definitions only). Backpressure: n/a.
package ctrl_pkg;

    typedef enum logic [1:0] {
        OP_MV  = 2'b00,
        OP_MVI = 2'b01,
        OP_ADD = 2'b10,
        OP_SUB = 2'b11
    } opcode_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_T1   = 2'd1,
        S_T2   = 2'd2,
        S_T3   = 2'd3
    } state_e;

    localparam int IR_OP_MSB = 7;
    localparam int IR_OP_LSB = 6;
    localparam int IR_RX_MSB = 5;
    localparam int IR_RX_LSB = 3;
    localparam int IR_RY_MSB = 2;
    localparam int IR_RY_LSB = 0;

endpackage

// File: rtl/dec3to8.sv
// dec3to8: 3-bit index to 8-bit one-hot, all zeros when en is low.
// Latency: combinational. Backpressure: n/a.
module dec3to8 (
    input  logic       en,
    input  logic [2:0] idx,
    output logic [7:0] onehot
);

    assign onehot = en ? (8'b1 << idx) : 8'b0;

endmodule

// File: rtl/ctrl_fsm.sv
// ctrl_fsm: multicycle datapath controller (mv/mvi/add, sub when CTRL_FSM_SUB_EN is defined).
// Latency: mv/mvi 2 cycles Run->Done, add/sub 4. Backpressure: Run ignored outside IDLE.
module ctrl_fsm
    import ctrl_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         Run,
    input  logic [W-1:0] DIN,
    output logic         IRin,
    output logic [7:0]   Rin,
    output logic [7:0]   Rout,
    output logic         Ain,
    output logic         Gin,
    output logic         AddSub,
    output logic         Gout,
    output logic         DINout,
    output logic         Done
);

    state_e       state_q, state_d;
    logic [W-1:0] ir_q, ir_d;

    opcode_e    op;
    logic [2:0] rx, ry;
    logic       rin_en, rout_en;
    logic [2:0] rin_idx, rout_idx;

    assign op = opcode_e'(ir_q[IR_OP_MSB:IR_OP_LSB]);
    assign rx = ir_q[IR_RX_MSB:IR_RX_LSB];
    assign ry = ir_q[IR_RY_MSB:IR_RY_LSB];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ir_d     = ir_q;
        IRin     = 1'b0;
        rin_en   = 1'b0;
        rin_idx  = rx;
        rout_en  = 1'b0;
        rout_idx = ry;
        Ain      = 1'b0;
        Gin      = 1'b0;
        AddSub   = 1'b0;
        Gout     = 1'b0;
        DINout   = 1'b0;
        Done     = 1'b0;
        case (state_q)
            S_IDLE: begin
                IRin = Run;
                if (Run) begin
                    ir_d    = DIN;
                    state_d = S_T1;
                end
            end
            S_T1: begin
                case (op)
                    OP_MV: begin
                        rout_en = 1'b1;
                        rin_en  = 1'b1;
                        Done    = 1'b1;
                        state_d = S_IDLE;
                    end
                    OP_MVI: begin
                        DINout  = 1'b1;
                        rin_en  = 1'b1;
                        Done    = 1'b1;
                        state_d = S_IDLE;
                    end
                    OP_ADD: begin
                        rout_en  = 1'b1;
                        rout_idx = rx;
                        Ain      = 1'b1;
                        state_d  = S_T2;
                    end
                    default: begin
`ifdef CTRL_FSM_SUB_EN
                        rout_en  = 1'b1;
                        rout_idx = rx;
                        Ain      = 1'b1;
                        state_d  = S_T2;
`else
                        // Opcode 11 is a NOP here: finish immediately, nothing on the bus.
                        Done    = 1'b1;
                        state_d = S_IDLE;
`endif
                    end
                endcase
            end
            S_T2: begin
                rout_en = 1'b1;
                Gin     = 1'b1;
                AddSub  = (op == OP_ADD);
                state_d = S_T3;
            end
            S_T3: begin
                Gout    = 1'b1;
                rin_en  = 1'b1;
                Done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    dec3to8 u_rin_dec (
        .en     (rin_en),
        .idx    (rin_idx),
        .onehot (Rin)
    );

    dec3to8 u_rout_dec (
        .en     (rout_en),
        .idx    (rout_idx),
        .onehot (Rout)
    );

endmodule

// File: tb/tb_ctrl_fsm.sv
// tb_ctrl_fsm: drives directed and random instruction streams into ctrl_fsm and
// compares every cycle's outputs against a per-instruction expected-cycle queue.
module tb_ctrl_fsm;

    typedef struct packed {
        logic       irin;
        logic [7:0] rin;
        logic [7:0] rout;
        logic       ain;
        logic       gin;
        logic       addsub;
        logic       gout;
        logic       dinout;
        logic       done;
    } outs_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       Run = 1'b0;
    logic [7:0] DIN = 8'h00;
    logic       IRin, Ain, Gin, AddSub, Gout, DINout, Done;
    logic [7:0] Rin, Rout;

    int n_checks = 0;
    int n_pass   = 0;
    bit model_valid = 1'b0;
    outs_t pend[$];

    always #5 clk = ~clk;

    ctrl_fsm #(.W(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .Run    (Run),
        .DIN    (DIN),
        .IRin   (IRin),
        .Rin    (Rin),
        .Rout   (Rout),
        .Ain    (Ain),
        .Gin    (Gin),
        .AddSub (AddSub),
        .Gout   (Gout),
        .DINout (DINout),
        .Done   (Done)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Expected per-cycle outputs of one instruction, from the instruction-set rules.
    task automatic push_instr(input logic [7:0] word);
        int    op, rx, ry;
        outs_t e;
        op = int'(word) / 64;
        rx = (int'(word) / 8) % 8;
        ry = int'(word) % 8;
        e = '0;
        if (op == 0) begin
            e.rout = 8'(1 << ry); e.rin = 8'(1 << rx); e.done = 1'b1;
            pend.push_back(e);
        end else if (op == 1) begin
            e.dinout = 1'b1; e.rin = 8'(1 << rx); e.done = 1'b1;
            pend.push_back(e);
        end else begin
`ifndef CTRL_FSM_SUB_EN
            if (op == 3) begin
                e.done = 1'b1;
                pend.push_back(e);
                return;
            end
`endif
            e.rout = 8'(1 << rx); e.ain = 1'b1;
            pend.push_back(e);
            e = '0;
            e.rout = 8'(1 << ry); e.gin = 1'b1; e.addsub = (op == 2);
            pend.push_back(e);
            e = '0;
            e.gout = 1'b1; e.rin = 8'(1 << rx); e.done = 1'b1;
            pend.push_back(e);
        end
    endtask

    task automatic cycle(input string tag, input logic r, input logic run, input logic [7:0] din);
        outs_t exp, got;
        int    drivers;
        @(negedge clk);
        rst = r;
        Run = run;
        DIN = din;
        #1;
        if (model_valid) begin
            if (pend.size() == 0) begin
                exp = '0;
                exp.irin = run;
            end else begin
                exp = pend[0];
            end
            got = '{IRin, Rin, Rout, Ain, Gin, AddSub, Gout, DINout, Done};
            check_eq(tag, 32'(got), 32'(exp));
            drivers = $countones(Rout) + int'(Gout) + int'(DINout);
            check_eq({tag, "_single_drv"}, 32'(drivers <= 1), 32'd1);
        end
        @(posedge clk);
        if (r) begin
            pend.delete();
            model_valid = 1'b1;
        end else if (model_valid) begin
            if (pend.size() != 0) void'(pend.pop_front());
            else if (run) push_instr(din);
        end
    endtask

    initial begin
        // Reset with Run held high, then release into an mvi R2.
        cycle("rst0", 1'b1, 1'b1, 8'h00);
        cycle("rst1", 1'b1, 1'b1, 8'h00);
        cycle("mvi_issue", 1'b0, 1'b1, 8'b01_010_000);
        cycle("mvi_t1", 1'b0, 1'b0, 8'h5A);
        cycle("idle0", 1'b0, 1'b0, 8'h00);

        cycle("add_issue", 1'b0, 1'b1, 8'b10_001_010);
        cycle("add_t1", 1'b0, 1'b1, 8'hFF);
        cycle("add_t2", 1'b0, 1'b1, 8'hFF);
        cycle("add_t3", 1'b0, 1'b0, 8'h00);

        cycle("sub_issue", 1'b0, 1'b1, 8'b11_011_000);
        cycle("sub_c1", 1'b0, 1'b0, 8'h00);
        cycle("sub_c2", 1'b0, 1'b0, 8'h00);
        cycle("sub_c3", 1'b0, 1'b0, 8'h00);
        cycle("sub_c4", 1'b0, 1'b0, 8'h00);

        // Reset lands in T2 of an add: nothing of the add may follow.
        cycle("abort_issue", 1'b0, 1'b1, 8'b10_001_010);
        cycle("abort_t1", 1'b0, 1'b0, 8'h00);
        cycle("abort_t2_rst", 1'b1, 1'b0, 8'h00);
        cycle("abort_after", 1'b0, 1'b0, 8'h00);
        cycle("abort_idle", 1'b0, 1'b0, 8'h00);

        // Back-to-back mv R0,R7 with Run held high throughout.
        cycle("b2b_issue", 1'b0, 1'b1, 8'b00_000_111);
        cycle("b2b_t1", 1'b0, 1'b1, 8'b00_000_111);
        cycle("b2b_issue2", 1'b0, 1'b1, 8'b00_000_111);
        cycle("b2b_t1b", 1'b0, 1'b1, 8'b00_111_111);
        cycle("b2b_end", 1'b0, 1'b0, 8'h00);

        for (int i = 0; i < 3000; i++) begin
            cycle("rand", ($urandom_range(0, 49) == 0), $urandom_range(0, 1) == 1, 8'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ctrl_fsm.md
CTRL_FSM -- requirements
Module: ctrl_fsm

Interface
REQ-001 Parameter W, default 8: width of DIN and the instruction register; only 8 is supported.
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 Run  input  1  start request, sampled only in IDLE.
REQ-005 DIN  input  W  instruction word in IDLE; immediate data in T1 of mvi.
REQ-006 IRin  output  1  high when the instruction register captures DIN.
REQ-007 Rin  output  8  one-hot register write enable, bit i for Ri.
REQ-008 Rout  output  8  one-hot register bus-drive enable.
REQ-009 Ain  output  1  ALU A register load.
REQ-010 Gin  output  1  ALU G register load.
REQ-011 AddSub  output  1  ALU operation select: 1 = add, 0 = subtract.
REQ-012 Gout  output  1  ALU G register bus-drive enable.
REQ-013 DINout  output  1  DIN bus-drive enable.
REQ-014 Done  output  1  one-cycle pulse marking the final cycle of an instruction.

Function
REQ-015 The instruction SHALL be IR[7:6] opcode (00 mv, 01 mvi, 10 add, 11 sub), IR[5:3] Rx and IR[2:0] Ry.
REQ-016 The FSM SHALL have states IDLE, T1, T2 and T3, with all outputs decoded combinationally from the state and IR.
REQ-017 IDLE: IRin=Run; if Run=1, IR<=DIN and state->T1; otherwise stay in IDLE.
REQ-018 mv: T1 drives Rout[Ry], Rin[Rx] and Done=1, then returns to IDLE.
REQ-019 mvi: T1 drives DINout, Rin[Rx] and Done=1, then returns to IDLE.
REQ-020 add/sub, T1: Rout[Rx] and Ain=1; next state T2.
REQ-021 add/sub, T2: Rout[Ry], Gin=1 and AddSub=1 for add or 0 for sub; next state T3.
REQ-022 add/sub, T3: Gout, Rin[Rx] and Done=1; next state IDLE.
REQ-023 Latency: mv and mvi take 2 cycles from Run acceptance to Done; add and sub take 4.
REQ-024 Run SHALL be ignored outside IDLE; back-to-back issue is allowed, so Run=1 in the cycle after Done is accepted.
REQ-025 In every cycle, at most one of Rout[*], Gout and DINout SHALL be high (single bus driver).
REQ-026 Any output not explicitly driven in a state SHALL be 0, including AddSub outside T2.
REQ-027 Rx==Ry SHALL be legal, with no special-casing.

Reset
REQ-028 When rst=1, the next state SHALL be IDLE and IR SHALL be 0; rst overrides Run and any in-flight instruction.
REQ-029 After the reset edge, all outputs SHALL be 0 (Done=0, IRin=0 unless Run=1).
REQ-030 An instruction aborted by reset SHALL produce no Done pulse and no further Rin.

Configuration
REQ-031 With CTRL_FSM_SUB_EN defined, opcode 11 SHALL execute sub as specified in REQ-020 to REQ-022.
REQ-032 Without CTRL_FSM_SUB_EN, opcode 11 SHALL be a NOP: T1 asserts only Done=1, then returns to IDLE with no bus driver and no Rin.

Structure
REQ-033 Shared package ctrl_pkg SHALL hold the opcode encodings, the state encodings and the IR field bit positions.
REQ-034 One sub-module, dec3to8 (3-bit index to 8-bit one-hot with enable), SHALL be instantiated twice, once for Rin and once for Rout.

Verification
REQ-035 Reset: rst=1 for 2 cycles with Run=1 -> state IDLE, and all outputs 0 except IRin in the cycle after rst falls.
REQ-036 mvi R2: DIN=8'b01_010_000 with Run=1, then DIN=8'h5A -> T1 has DINout=1, Rin=8'h04 and Done=1.
REQ-037 add R1,R2: DIN=8'b10_001_010 -> T1 Rout=8'h02 and Ain=1; T2 Rout=8'h04, Gin=1 and AddSub=1; T3 Gout=1, Rin=8'h02 and Done=1.
REQ-038 sub R3,R0: DIN=8'b11_011_000 -> T2 AddSub=0; in the build without CTRL_FSM_SUB_EN, only Done=1 in T1.
REQ-039 Reset in T2 of add -> next cycle IDLE, with no Gout, no Rin and no Done.
REQ-040 Back-to-back mv R0,R7 then Run held high -> second IRin in the cycle after Done; the REQ-025 single-driver check holds every cycle.
